// File: rtl/ingress_dispatcher_pkg.sv
// Shared widths, opcode class and FSM encodings for the ingress dispatcher.
// Packet classification lives here so the top and any future users agree on it.
package ingress_dispatcher_pkg;

    localparam int unsigned PKT_HEAD_BUS_WIDTH = 64;
    localparam int unsigned PKT_DATA_BUS_WIDTH = 64;
    localparam int unsigned OPCODE_CLS_WIDTH   = 5;
    localparam int unsigned STAT_WIDTH         = 32;

    // Low five bits of the BTH opcode that bound the response/ACK range
    localparam logic [OPCODE_CLS_WIDTH-1:0] OP_RESP_FIRST = 5'h0D;
    localparam logic [OPCODE_CLS_WIDTH-1:0] OP_RESP_LAST  = 5'h12;
    localparam logic [OPCODE_CLS_WIDTH-1:0] OP_RSVD_15    = 5'h15;
    localparam logic [OPCODE_CLS_WIDTH-1:0] OP_RSVD_FIRST = 5'h18;

    typedef enum logic [1:0] {
        CLS_REQ  = 2'd0,
        CLS_RESP = 2'd1,
        CLS_DROP = 2'd2
    } pkt_class_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FWD_REQ  = 2'd1,
        ST_FWD_RESP = 2'd2,
        ST_DROP     = 2'd3
    } disp_state_e;

    function automatic pkt_class_e classify(input logic [OPCODE_CLS_WIDTH-1:0] op);
        pkt_class_e cls;
        if (op >= OP_RESP_FIRST && op <= OP_RESP_LAST) begin
            cls = CLS_RESP;
        end else if (op == OP_RSVD_15 || op >= OP_RSVD_FIRST) begin
            cls = CLS_DROP;
        end else begin
            cls = CLS_REQ;
        end
        return cls;
    endfunction

    function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
        return (v == {STAT_WIDTH{1'b1}}) ? v : v + STAT_WIDTH'(1);
    endfunction

endpackage

// File: rtl/ingress_dispatcher_pkt_slice_reg.sv
// One-entry valid/ready register slice carrying head, data, start and last.
// Accepts a new beat whenever empty or its current beat leaves this cycle.
module pkt_slice_reg
    import ingress_dispatcher_pkg::*;
#(
    parameter int unsigned HEAD_WIDTH = PKT_HEAD_BUS_WIDTH,
    parameter int unsigned DATA_WIDTH = PKT_DATA_BUS_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [HEAD_WIDTH-1:0] in_head,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_start,
    input  logic                  in_last,
    output logic                  in_ready_c,
    output logic                  out_valid,
    output logic [HEAD_WIDTH-1:0] out_head,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_start,
    output logic                  out_last,
    input  logic                  out_ready
);

    assign in_ready_c = !out_valid || out_ready;

    // Payload only moves on a real load so it stays stable while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_head  <= '0;
            out_data  <= '0;
            out_start <= 1'b0;
            out_last  <= 1'b0;
        end else if (in_ready_c) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_head  <= in_head;
                out_data  <= in_data;
                out_start <= in_start;
                out_last  <= in_last;
            end
        end
    end

endmodule

// File: rtl/ingress_dispatcher.sv
// Steers whole ingress packets by BTH opcode to the requester or responder engine.
// Optional counters: define INGRESS_DISPATCH_STATS_EN to add the stat_* outputs.
module ingress_dispatcher
    import ingress_dispatcher_pkg::*;
#(
    parameter int unsigned HEAD_WIDTH = PKT_HEAD_BUS_WIDTH,
    parameter int unsigned DATA_WIDTH = PKT_DATA_BUS_WIDTH,
    parameter int unsigned OPCODE_LSB = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ingress_pkt_valid,
    input  logic [HEAD_WIDTH-1:0] ingress_pkt_head,
    input  logic [DATA_WIDTH-1:0] ingress_pkt_data,
    input  logic                  ingress_pkt_start,
    input  logic                  ingress_pkt_last,
    output logic                  ingress_pkt_ready,
    output logic                  req_trans_pkt_in_valid,
    output logic [HEAD_WIDTH-1:0] req_trans_pkt_in_head,
    output logic [DATA_WIDTH-1:0] req_trans_pkt_in_data,
    output logic                  req_trans_pkt_in_start,
    output logic                  req_trans_pkt_in_last,
    input  logic                  req_trans_pkt_in_ready,
    output logic                  resp_trans_pkt_in_valid,
    output logic [HEAD_WIDTH-1:0] resp_trans_pkt_in_head,
    output logic [DATA_WIDTH-1:0] resp_trans_pkt_in_data,
    output logic                  resp_trans_pkt_in_start,
    output logic                  resp_trans_pkt_in_last,
    input  logic                  resp_trans_pkt_in_ready,
    output logic                  proto_err
`ifdef INGRESS_DISPATCH_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0] stat_req_pkt_cnt,
    output logic [STAT_WIDTH-1:0] stat_resp_pkt_cnt,
    output logic [STAT_WIDTH-1:0] stat_drop_pkt_cnt,
    output logic [STAT_WIDTH-1:0] stat_err_cnt
`endif
);

    disp_state_e           state_q;
    disp_state_e           state_d;
    pkt_class_e            in_cls_c;
    pkt_class_e            tgt_c;
    logic [HEAD_WIDTH-1:0] head_q;
    logic [HEAD_WIDTH-1:0] fwd_head_c;
    logic                  fwd_start_c;
    logic                  ready_c;
    logic                  accept_c;
    logic                  new_pkt_c;
    logic                  err_c;
    logic                  req_push_c;
    logic                  resp_push_c;
    logic                  req_slice_ready_c;
    logic                  resp_slice_ready_c;

    assign in_cls_c          = classify(ingress_pkt_head[OPCODE_LSB +: OPCODE_CLS_WIDTH]);
    assign ingress_pkt_ready = ready_c;

    // Route selection, handshake and framing checks for the current beat
    always_comb begin
        state_d     = state_q;
        tgt_c       = CLS_DROP;
        fwd_head_c  = head_q;
        fwd_start_c = 1'b0;
        ready_c     = 1'b0;
        accept_c    = 1'b0;
        new_pkt_c   = 1'b0;
        err_c       = 1'b0;
        req_push_c  = 1'b0;
        resp_push_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ingress_pkt_start) begin
                    tgt_c       = in_cls_c;
                    fwd_head_c  = ingress_pkt_head;
                    fwd_start_c = 1'b1;
                end
            end
            ST_FWD_REQ:  tgt_c = CLS_REQ;
            ST_FWD_RESP: tgt_c = CLS_RESP;
            default:     tgt_c = CLS_DROP;
        endcase

        // REQ-class packets go to the responder engine, RESP-class to the requester
        case (tgt_c)
            CLS_REQ:  ready_c = resp_slice_ready_c && !rst;
            CLS_RESP: ready_c = req_slice_ready_c && !rst;
            default:  ready_c = !rst;
        endcase

        accept_c    = ingress_pkt_valid && ready_c;
        resp_push_c = accept_c && (tgt_c == CLS_REQ);
        req_push_c  = accept_c && (tgt_c == CLS_RESP);

        if (accept_c) begin
            if (state_q == ST_IDLE) begin
                if (ingress_pkt_start) begin
                    new_pkt_c = 1'b1;
                    if (!ingress_pkt_last) begin
                        case (in_cls_c)
                            CLS_REQ:  state_d = ST_FWD_REQ;
                            CLS_RESP: state_d = ST_FWD_RESP;
                            default:  state_d = ST_DROP;
                        endcase
                    end
                end else begin
                    err_c = 1'b1;
                end
            end else begin
                err_c = ingress_pkt_start;
                if (ingress_pkt_last) begin
                    state_d = ST_IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            head_q    <= '0;
            proto_err <= 1'b0;
        end else begin
            state_q   <= state_d;
            proto_err <= err_c;
            if (new_pkt_c) begin
                head_q <= ingress_pkt_head;
            end
        end
    end

    pkt_slice_reg #(
        .HEAD_WIDTH(HEAD_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_req_slice (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (req_push_c),
        .in_head   (fwd_head_c),
        .in_data   (ingress_pkt_data),
        .in_start  (fwd_start_c),
        .in_last   (ingress_pkt_last),
        .in_ready_c(req_slice_ready_c),
        .out_valid (req_trans_pkt_in_valid),
        .out_head  (req_trans_pkt_in_head),
        .out_data  (req_trans_pkt_in_data),
        .out_start (req_trans_pkt_in_start),
        .out_last  (req_trans_pkt_in_last),
        .out_ready (req_trans_pkt_in_ready)
    );

    pkt_slice_reg #(
        .HEAD_WIDTH(HEAD_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_resp_slice (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (resp_push_c),
        .in_head   (fwd_head_c),
        .in_data   (ingress_pkt_data),
        .in_start  (fwd_start_c),
        .in_last   (ingress_pkt_last),
        .in_ready_c(resp_slice_ready_c),
        .out_valid (resp_trans_pkt_in_valid),
        .out_head  (resp_trans_pkt_in_head),
        .out_data  (resp_trans_pkt_in_data),
        .out_start (resp_trans_pkt_in_start),
        .out_last  (resp_trans_pkt_in_last),
        .out_ready (resp_trans_pkt_in_ready)
    );

`ifdef INGRESS_DISPATCH_STATS_EN
    // Saturating packet and error counters
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_req_pkt_cnt  <= '0;
            stat_resp_pkt_cnt <= '0;
            stat_drop_pkt_cnt <= '0;
            stat_err_cnt      <= '0;
        end else begin
            if (new_pkt_c && in_cls_c == CLS_REQ) begin
                stat_req_pkt_cnt <= sat_inc(stat_req_pkt_cnt);
            end
            if (new_pkt_c && in_cls_c == CLS_RESP) begin
                stat_resp_pkt_cnt <= sat_inc(stat_resp_pkt_cnt);
            end
            if (new_pkt_c && in_cls_c == CLS_DROP) begin
                stat_drop_pkt_cnt <= sat_inc(stat_drop_pkt_cnt);
            end
            if (err_c) begin
                stat_err_cnt <= sat_inc(stat_err_cnt);
            end
        end
    end
`endif

endmodule

// File: tb/tb_ingress_dispatcher.sv
// Bench for ingress_dispatcher: directed scenarios plus random packets against a packet-level model.
// Build with INGRESS_DISPATCH_STATS_EN defined to also check the statistics counters.
module tb_ingress_dispatcher;
    import ingress_dispatcher_pkg::*;

    localparam int unsigned HW = PKT_HEAD_BUS_WIDTH;
    localparam int unsigned DW = PKT_DATA_BUS_WIDTH;

    typedef struct packed {
        logic [HW-1:0] head;
        logic [DW-1:0] data;
        logic          start;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ingress_pkt_valid = 1'b0;
    logic [HW-1:0] ingress_pkt_head = '0;
    logic [DW-1:0] ingress_pkt_data = '0;
    logic          ingress_pkt_start = 1'b0;
    logic          ingress_pkt_last = 1'b0;
    logic          ingress_pkt_ready;
    logic          req_v, req_start, req_last;
    logic [HW-1:0] req_head;
    logic [DW-1:0] req_data;
    logic          req_ready = 1'b1;
    logic          resp_v, resp_start, resp_last;
    logic [HW-1:0] resp_head;
    logic [DW-1:0] resp_data;
    logic          resp_ready = 1'b1;
    logic          proto_err;
`ifdef INGRESS_DISPATCH_STATS_EN
    logic [31:0]   stat_req, stat_resp, stat_drop, stat_err;
`endif

    ingress_dispatcher dut (
        .clk                    (clk),
        .rst                    (rst),
        .ingress_pkt_valid      (ingress_pkt_valid),
        .ingress_pkt_head       (ingress_pkt_head),
        .ingress_pkt_data       (ingress_pkt_data),
        .ingress_pkt_start      (ingress_pkt_start),
        .ingress_pkt_last       (ingress_pkt_last),
        .ingress_pkt_ready      (ingress_pkt_ready),
        .req_trans_pkt_in_valid (req_v),
        .req_trans_pkt_in_head  (req_head),
        .req_trans_pkt_in_data  (req_data),
        .req_trans_pkt_in_start (req_start),
        .req_trans_pkt_in_last  (req_last),
        .req_trans_pkt_in_ready (req_ready),
        .resp_trans_pkt_in_valid(resp_v),
        .resp_trans_pkt_in_head (resp_head),
        .resp_trans_pkt_in_data (resp_data),
        .resp_trans_pkt_in_start(resp_start),
        .resp_trans_pkt_in_last (resp_last),
        .resp_trans_pkt_in_ready(resp_ready),
        .proto_err              (proto_err)
`ifdef INGRESS_DISPATCH_STATS_EN
        ,
        .stat_req_pkt_cnt       (stat_req),
        .stat_resp_pkt_cnt      (stat_resp),
        .stat_drop_pkt_cnt      (stat_drop),
        .stat_err_cnt           (stat_err)
`endif
    );

    always #5 clk = ~clk;

    beat_t req_q[$];
    beat_t resp_q[$];
    beat_t cur_pkt[$];
    int    vectors = 0;
    int    miscompares = 0;
    int    exp_err = 0;
    int    obs_err = 0;
    int    exp_req_cnt = 0, exp_resp_cnt = 0, exp_drop_cnt = 0;
    int    req_pct = 100, resp_pct = 100;
    logic  req_stall = 1'b0, resp_stall = 1'b0;
    beat_t req_prev, resp_prev;

    // Reference classification: 0 = request (to responder), 1 = response (to requester), 2 = dropped
    function automatic int tb_class(input logic [7:0] op);
        int low;
        low = int'(op & 8'h1F);
        if (low >= 13 && low <= 18) return 1;
        if (low == 21 || low >= 24) return 2;
        return 0;
    endfunction

    always @(posedge clk) begin
        #1;
        req_ready  = ($urandom_range(99) < req_pct);
        resp_ready = ($urandom_range(99) < resp_pct);
    end

    // Output monitor: scoreboard comparison, stall stability and error pulse counting
    always @(negedge clk) begin
        beat_t cur, exp;
        if (rst) begin
            req_stall  = 1'b0;
            resp_stall = 1'b0;
        end else begin
            if (proto_err === 1'b1) obs_err++;
            cur = '{head: req_head, data: req_data, start: req_start, last: req_last};
            if (req_stall) begin
                vectors++;
                if (req_v !== 1'b1 || cur !== req_prev) begin
                    $display("FAIL req_stall_hold: got v=%b %h want v=1 %h", req_v, cur, req_prev);
                    miscompares++;
                end
            end
            if (req_v === 1'b1 && req_ready) begin
                vectors++;
                if (req_q.size() == 0) begin
                    $display("FAIL req_unexpected: got %h want nothing", cur);
                    miscompares++;
                end else begin
                    exp = req_q.pop_front();
                    if (cur !== exp) begin
                        $display("FAIL req_beat: got %h want %h", cur, exp);
                        miscompares++;
                    end
                end
            end
            req_stall = (req_v === 1'b1) && !req_ready;
            req_prev  = cur;

            cur = '{head: resp_head, data: resp_data, start: resp_start, last: resp_last};
            if (resp_stall) begin
                vectors++;
                if (resp_v !== 1'b1 || cur !== resp_prev) begin
                    $display("FAIL resp_stall_hold: got v=%b %h want v=1 %h", resp_v, cur, resp_prev);
                    miscompares++;
                end
            end
            if (resp_v === 1'b1 && resp_ready) begin
                vectors++;
                if (resp_q.size() == 0) begin
                    $display("FAIL resp_unexpected: got %h want nothing", cur);
                    miscompares++;
                end else begin
                    exp = resp_q.pop_front();
                    if (cur !== exp) begin
                        $display("FAIL resp_beat: got %h want %h", cur, exp);
                        miscompares++;
                    end
                end
            end
            resp_stall = (resp_v === 1'b1) && !resp_ready;
            resp_prev  = cur;
        end
    end

    task automatic build_pkt(input logic [7:0] op, input int n);
        logic [HW-1:0] h;
        beat_t         b;
        int            c;
        h       = HW'({$urandom(), $urandom()});
        h[7:0]  = op;
        c       = tb_class(op);
        cur_pkt.delete();
        for (int i = 0; i < n; i++) begin
            b.head  = h;
            b.data  = DW'({$urandom(), $urandom()});
            b.start = (i == 0);
            b.last  = (i == n - 1);
            cur_pkt.push_back(b);
            if (c == 0) resp_q.push_back(b);
            else if (c == 1) req_q.push_back(b);
        end
        if (c == 0) exp_req_cnt++;
        else if (c == 1) exp_resp_cnt++;
        else exp_drop_cnt++;
    endtask

    // Called at posedge+1; returns at posedge+1 after the beat is accepted
    task automatic send_beat(input beat_t b, output int waits);
        ingress_pkt_valid = 1'b1;
        ingress_pkt_head  = b.head;
        ingress_pkt_data  = b.data;
        ingress_pkt_start = b.start;
        ingress_pkt_last  = b.last;
        waits = 0;
        do begin
            @(negedge clk);
            waits++;
        end while (ingress_pkt_ready !== 1'b1 && waits < 300);
        if (ingress_pkt_ready !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: got ready=%b want 1 within 300 cycles", ingress_pkt_ready);
        end
        @(posedge clk);
        #1;
        ingress_pkt_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        req_pct  = 100;
        resp_pct = 100;
        while ((req_q.size() != 0 || resp_q.size() != 0) && k < 300) begin
            @(negedge clk);
            k++;
        end
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (req_q.size() != 0 || resp_q.size() != 0) begin
            $display("FAIL drain: got %0d/%0d beats pending want 0/0", req_q.size(), resp_q.size());
            miscompares++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (ingress_pkt_ready !== 1'b0 || proto_err !== 1'b0) begin
            $display("FAIL reset_ctrl: got ready=%b err=%b want 0 0", ingress_pkt_ready, proto_err);
            miscompares++;
        end
        vectors++;
        if ({req_v, req_start, req_last, req_head, req_data} !== '0) begin
            $display("FAIL reset_req_out: got v=%b h=%h d=%h want zeros", req_v, req_head, req_data);
            miscompares++;
        end
        vectors++;
        if ({resp_v, resp_start, resp_last, resp_head, resp_data} !== '0) begin
            $display("FAIL reset_resp_out: got v=%b h=%h d=%h want zeros", resp_v, resp_head, resp_data);
            miscompares++;
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_send_only();
        int w;
        build_pkt(8'h04, 1);
        send_beat(cur_pkt[0], w);
        vectors++;
        if (w != 1) begin
            $display("FAIL send_only_ready: got %0d cycles want 1", w);
            miscompares++;
        end
        @(negedge clk);
        vectors++;
        if (resp_v !== 1'b1 || req_v !== 1'b0 || resp_start !== 1'b1 || resp_last !== 1'b1) begin
            $display("FAIL send_only_latency: got resp_v=%b req_v=%b s=%b l=%b want 1 0 1 1",
                     resp_v, req_v, resp_start, resp_last);
            miscompares++;
        end
        drain();
    endtask

    task automatic test_read_resp();
        int w;
        build_pkt(8'h0D, 4);
        for (int i = 0; i < 4; i++) begin
            send_beat(cur_pkt[i], w);
            vectors++;
            if (w != 1) begin
                $display("FAIL read_resp_throughput: beat %0d got %0d cycles want 1", i, w);
                miscompares++;
            end
        end
        drain();
    endtask

    task automatic test_drop();
        int w;
        build_pkt(8'h18, 3);
        for (int i = 0; i < 3; i++) begin
            send_beat(cur_pkt[i], w);
            vectors++;
            if (w != 1) begin
                $display("FAIL drop_ready: beat %0d got %0d cycles want 1", i, w);
                miscompares++;
            end
        end
        @(negedge clk);
        vectors++;
        if (req_v !== 1'b0 || resp_v !== 1'b0) begin
            $display("FAIL drop_no_output: got req_v=%b resp_v=%b want 0 0", req_v, resp_v);
            miscompares++;
        end
`ifdef INGRESS_DISPATCH_STATS_EN
        vectors++;
        if (stat_drop !== 32'(exp_drop_cnt)) begin
            $display("FAIL drop_stat: got %0d want %0d", stat_drop, exp_drop_cnt);
            miscompares++;
        end
`endif
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic test_backpressure();
        int w;
        resp_pct = 0;
        @(posedge clk);
        #1;
        build_pkt(8'h02, 3);
        send_beat(cur_pkt[0], w);
        ingress_pkt_valid = 1'b1;
        ingress_pkt_head  = cur_pkt[1].head;
        ingress_pkt_data  = cur_pkt[1].data;
        ingress_pkt_start = cur_pkt[1].start;
        ingress_pkt_last  = cur_pkt[1].last;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if (ingress_pkt_ready !== 1'b0 || resp_v !== 1'b1) begin
                $display("FAIL backpressure_hold: cycle %0d got ready=%b resp_v=%b want 0 1",
                         i, ingress_pkt_ready, resp_v);
                miscompares++;
            end
        end
        resp_pct = 100;
        send_beat(cur_pkt[1], w);
        send_beat(cur_pkt[2], w);
        drain();
    endtask

    task automatic test_framing();
        int    w;
        beat_t b;
        b.head  = HW'({$urandom(), $urandom()});
        b.data  = DW'({$urandom(), $urandom()});
        b.start = 1'b0;
        b.last  = 1'b0;
        send_beat(b, w);
        exp_err++;
        vectors++;
        if (w != 1) begin
            $display("FAIL framing_idle_ready: got %0d cycles want 1", w);
            miscompares++;
        end
        @(negedge clk);
        vectors++;
        if (proto_err !== 1'b1 || req_v !== 1'b0 || resp_v !== 1'b0) begin
            $display("FAIL framing_idle_drop: got err=%b req_v=%b resp_v=%b want 1 0 0", proto_err, req_v, resp_v);
            miscompares++;
        end
        @(posedge clk);
        #1;
        build_pkt(8'h0A, 3);
        cur_pkt[1].start = 1'b1;
        cur_pkt[1].head  = ~cur_pkt[1].head;
        cur_pkt[1].head[7:0] = 8'h0D;
        exp_err++;
        for (int i = 0; i < 3; i++) send_beat(cur_pkt[i], w);
        drain();
        vectors++;
        if (obs_err != exp_err) begin
            $display("FAIL framing_err_count: got %0d pulses want %0d", obs_err, exp_err);
            miscompares++;
        end
    endtask

    task automatic test_reset_mid();
        int w;
        build_pkt(8'h00, 4);
        send_beat(cur_pkt[0], w);
        send_beat(cur_pkt[1], w);
        ingress_pkt_valid = 1'b1;
        ingress_pkt_head  = cur_pkt[2].head;
        ingress_pkt_data  = cur_pkt[2].data;
        ingress_pkt_start = cur_pkt[2].start;
        ingress_pkt_last  = cur_pkt[2].last;
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (ingress_pkt_ready !== 1'b0) begin
            $display("FAIL reset_mid_ready: got %b want 0", ingress_pkt_ready);
            miscompares++;
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        ingress_pkt_valid = 1'b0;
        req_q.delete();
        resp_q.delete();
        exp_req_cnt  = 0;
        exp_resp_cnt = 0;
        exp_drop_cnt = 0;
        exp_err      = 0;
        obs_err      = 0;
        @(negedge clk);
        vectors++;
        if (req_v !== 1'b0 || resp_v !== 1'b0 || ingress_pkt_ready !== 1'b1) begin
            $display("FAIL reset_mid_flush: got req_v=%b resp_v=%b ready=%b want 0 0 1", req_v, resp_v, ingress_pkt_ready);
            miscompares++;
        end
        @(posedge clk);
        #1;
        build_pkt(8'h10, 2);
        for (int i = 0; i < 2; i++) send_beat(cur_pkt[i], w);
        drain();
    endtask

    task automatic test_random();
        int w;
        for (int p = 0; p < 60; p++) begin
            req_pct  = int'($urandom_range(30, 100));
            resp_pct = int'($urandom_range(30, 100));
            build_pkt(8'($urandom_range(255)), int'($urandom_range(1, 4)));
            for (int i = 0; i < cur_pkt.size(); i++) begin
                send_beat(cur_pkt[i], w);
                if ($urandom_range(3) == 0) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        drain();
        vectors++;
        if (obs_err != exp_err) begin
            $display("FAIL random_err_count: got %0d pulses want %0d", obs_err, exp_err);
            miscompares++;
        end
`ifdef INGRESS_DISPATCH_STATS_EN
        vectors++;
        if (stat_req !== 32'(exp_req_cnt) || stat_resp !== 32'(exp_resp_cnt) ||
            stat_drop !== 32'(exp_drop_cnt) || stat_err !== 32'(exp_err)) begin
            $display("FAIL stats: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", stat_req, stat_resp,
                     stat_drop, stat_err, exp_req_cnt, exp_resp_cnt, exp_drop_cnt, exp_err);
            miscompares++;
        end
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_send_only();
        test_read_resp();
        test_drop();
        test_backpressure();
        test_framing();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
